// File: rtl/sys_bridge_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_bridge_n_pkg
// Description : Shared types and constants for the sys_bridge_n bridge:
//               transaction-state encodings, the data word type and the
//               base/mask pairs of the standard device map.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_bridge_n_pkg;

    // Transaction state encodings (explicit 2-bit width)
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = c_ST_IDLE,
        S_ACCESS = c_ST_ACCESS,
        S_RESP   = c_ST_RESP
    } state_t;

    // Processor data word
    typedef logic [31:0] word_t;

    // Standard map: data memory, timer0, timer1
    localparam logic [15:0] c_DM_BASE   = 16'h0000;
    localparam logic [15:0] c_DM_MASK   = 16'hC000;
    localparam logic [15:0] c_TIM0_BASE = 16'h7F00;
    localparam logic [15:0] c_TIM0_MASK = 16'hFFF0;
    localparam logic [15:0] c_TIM1_BASE = 16'h7F10;
    localparam logic [15:0] c_TIM1_MASK = 16'hFFF0;

endpackage
`default_nettype wire

// File: rtl/sys_bridge_n_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_bridge_n_if
// Description : Bus bundle between the processor data port, the bridge and
//               the N memory-mapped devices.
//               pr_*   : processor request / response
//               dev_*  : latched device bus, per-device read data/ack/irq
//               hw_int : registered interrupt vector to CP0
//               modport slave  - the bridge
//               modport master - the processor + device side
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_bridge_n_if #(
    parameter int N_DEV  = 7,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                    pr_req;
    logic                    pr_we;
    logic [ADDR_W-1:0]       pr_addr;
    logic [3:0]              pr_be;
    logic [DATA_W-1:0]       pr_wd;
    logic [DATA_W-1:0]       pr_rd;
    logic                    pr_ready;
    logic                    pr_err;
    logic [ADDR_W-1:0]       dev_addr;
    logic [3:0]              dev_be;
    logic [DATA_W-1:0]       dev_wd;
    logic                    dev_we;
    logic [N_DEV-1:0]        dev_sel;
    logic [N_DEV*DATA_W-1:0] dev_rd;
    logic [N_DEV-1:0]        dev_ack;
    logic [N_DEV-1:0]        dev_irq;
    logic [5:0]              hw_int;

    modport slave (
        input  pr_req, pr_we, pr_addr, pr_be, pr_wd,
        output pr_rd, pr_ready, pr_err,
        output dev_addr, dev_be, dev_wd, dev_we, dev_sel,
        input  dev_rd, dev_ack, dev_irq,
        output hw_int
    );

    modport master (
        output pr_req, pr_we, pr_addr, pr_be, pr_wd,
        input  pr_rd, pr_ready, pr_err,
        input  dev_addr, dev_be, dev_wd, dev_we, dev_sel,
        output dev_rd, dev_ack, dev_irq,
        input  hw_int
    );
endinterface
`default_nettype wire

// File: rtl/sys_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : sys_addr_decode
// Description : Combinational priority base/mask address decoder. Channel i
//               matches when (addr & mask_i) == base_i; when several channels
//               match, the lowest index wins.
//               i_addr : address to decode
//               o_sel  : one-hot channel select (all zero on miss)
//               o_hit  : at least one channel matched
// Revision    : 1.0 - initial release
// ============================================================================
module sys_addr_decode #(
    parameter int                      N_DEV    = 7,
    parameter int                      ADDR_W   = 16,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = '0,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = '1
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic      [N_DEV-1:0]  o_sel,
    output logic                   o_hit
);

    logic [N_DEV-1:0] w_match;

    generate
        for (genvar i = 0; i < N_DEV; i++) begin : g_match
            assign w_match[i] =
                ((i_addr & DEV_MASK[i*ADDR_W +: ADDR_W]) == DEV_BASE[i*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // First match scanning upward claims the select; later matches are masked.
    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (w_match[i] && !o_hit) begin
                o_sel[i] = 1'b1;
                o_hit    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_bridge_n.sv
`default_nettype none
// ============================================================================
// Module      : sys_bridge_n
// Description : Registered core-to-device bridge. Latches a processor request,
//               decodes it onto one of N_DEV device channels and waits for
//               that channel's acknowledge (wait states allowed), then returns
//               a one-cycle pr_ready with read data and an error flag.
//               Device irq lines 0..5 are registered into hw_int.
//               clk   : system clock, rising edge
//               reset : synchronous, active-high
//               bus   : sys_bridge_n_if.slave (processor and device signals)
// Options     : SYS_BRIDGE_TIMEOUT_EN - abort an ACCESS after TIMEOUT cycles
//               without acknowledge (pr_err=1, pr_rd=0).
// Revision    : 1.0 - initial release
// ============================================================================
module sys_bridge_n
    import sys_bridge_n_pkg::*;
#(
    parameter int                      N_DEV    = 7,
    parameter int                      ADDR_W   = 16,
    parameter int                      DATA_W   = 32,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = {N_DEV{{ADDR_W{1'b0}}}},
    parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = {N_DEV*ADDR_W{1'b1}},
    parameter int                      TIMEOUT  = 15
) (
    input  wire logic       clk,
    input  wire logic       reset,
    sys_bridge_n_if.slave   bus
);

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [DATA_W-1:0]   r_wd;
    logic                r_we;
    logic [N_DEV-1:0]    r_sel;
    logic [DATA_W-1:0]   r_rd;
    logic                r_err;
    logic [5:0]          r_hw_int;

    logic [N_DEV-1:0]    w_dec_sel;
    logic                w_dec_hit;
    logic                w_latch;
    logic                w_rsp_load;
    logic [DATA_W-1:0]   w_rsp_rd;
    logic                w_rsp_err;
    logic                w_ack_sel;
    logic [DATA_W-1:0]   w_rd_mux;
    logic [5:0]          w_irq_in;
    logic                w_unused;

    sys_addr_decode #(
        .N_DEV    (N_DEV),
        .ADDR_W   (ADDR_W),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .i_addr (bus.pr_addr),
        .o_sel  (w_dec_sel),
        .o_hit  (w_dec_hit)
    );

    // Only the selected channel's acknowledge counts.
    assign w_ack_sel = |(bus.dev_ack & r_sel);

    // One-hot AND-OR read mux over the selected channel.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < N_DEV; i++) begin
            w_rd_mux = w_rd_mux | (bus.dev_rd[i*DATA_W +: DATA_W] & {DATA_W{r_sel[i]}});
        end
    end

`ifdef SYS_BRIDGE_TIMEOUT_EN
    localparam int                c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    // Counts ACCESS cycles without acknowledge; zero in the first ACCESS cycle.
    logic [c_TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state != S_ACCESS)) begin
            r_tmo_cnt <= '0;
        end else if (!w_ack_sel) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end
`endif

    // Next-state and response-capture logic
    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_rsp_load = 1'b0;
        w_rsp_rd   = '0;
        w_rsp_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.pr_req) begin
                    w_latch = 1'b1;
                    if (w_dec_hit) begin
                        w_next = S_ACCESS;
                    end else begin
                        // Decode miss: answer directly, no device is touched.
                        w_next     = S_RESP;
                        w_rsp_load = 1'b1;
                        w_rsp_err  = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (w_ack_sel) begin
                    // Read data is captured on writes as well.
                    w_next     = S_RESP;
                    w_rsp_load = 1'b1;
                    w_rsp_rd   = w_rd_mux;
                end
`ifdef SYS_BRIDGE_TIMEOUT_EN
                else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_next     = S_RESP;
                    w_rsp_load = 1'b1;
                    w_rsp_err  = 1'b1;
                end
`endif
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_be     <= '0;
            r_wd     <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
            r_hw_int <= '0;
        end else begin
            r_state  <= w_next;
            r_hw_int <= w_irq_in;
            if (w_latch) begin
                r_addr <= bus.pr_addr;
                r_be   <= bus.pr_be;
                r_wd   <= bus.pr_wd;
                r_we   <= bus.pr_we;
                r_sel  <= w_dec_sel;
            end
            if (w_rsp_load) begin
                r_rd  <= w_rsp_rd;
                r_err <= w_rsp_err;
            end
        end
    end

    // Channels 6 and above have no interrupt line into CP0.
    generate
        for (genvar i = 0; i < 6; i++) begin : g_irq
            if (i < N_DEV) begin : g_conn
                assign w_irq_in[i] = bus.dev_irq[i];
            end else begin : g_tie
                assign w_irq_in[i] = 1'b0;
            end
        end
    endgenerate

    // Upper irq lines and TIMEOUT (default build) are intentionally not consumed.
    assign w_unused = ^{bus.dev_irq, (TIMEOUT == 0)};

    assign bus.dev_addr = r_addr;
    assign bus.dev_be   = r_be;
    assign bus.dev_wd   = r_wd;
    assign bus.dev_we   = (r_state == S_ACCESS) & r_we;
    assign bus.dev_sel  = (r_state == S_ACCESS) ? r_sel : '0;
    assign bus.pr_ready = (r_state == S_RESP);
    assign bus.pr_rd    = r_rd;
    assign bus.pr_err   = r_err;
    assign bus.hw_int   = r_hw_int;

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_bridge_n
// Description : Self-checking bench for sys_bridge_n on a 7-channel map
//               (DM, timer0, timer1, UART, switches, LEDs, overlapping aux).
//               Directed vector table, randomized transactions against a
//               map-level reference model, and hand sequences for reset
//               during ACCESS, interrupts and (with SYS_BRIDGE_TIMEOUT_EN)
//               the access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_bridge_n;
    import sys_bridge_n_pkg::*;

    localparam int N   = 7;
    localparam int TMO = 15;

    localparam logic [15:0] MAP_BASE [N] = '{c_DM_BASE, c_TIM0_BASE, c_TIM1_BASE,
                                             16'h7F20, 16'h7F30, 16'h7F40, 16'h0000};
    localparam logic [15:0] MAP_MASK [N] = '{c_DM_MASK, c_TIM0_MASK, c_TIM1_MASK,
                                             16'hFFF0, 16'hFFF0, 16'hFFC0, 16'hFF00};
    localparam logic [N*16-1:0] P_BASE = {MAP_BASE[6], MAP_BASE[5], MAP_BASE[4], MAP_BASE[3],
                                          MAP_BASE[2], MAP_BASE[1], MAP_BASE[0]};
    localparam logic [N*16-1:0] P_MASK = {MAP_MASK[6], MAP_MASK[5], MAP_MASK[4], MAP_MASK[3],
                                          MAP_MASK[2], MAP_MASK[1], MAP_MASK[0]};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sys_bridge_n_if #(.N_DEV(N), .ADDR_W(16), .DATA_W(32)) bus ();

    sys_bridge_n #(
        .N_DEV(N), .ADDR_W(16), .DATA_W(32),
        .DEV_BASE(P_BASE), .DEV_MASK(P_MASK), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode: first map entry whose masked address equals its base.
    function automatic int model_decode(input logic [15:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & MAP_MASK[i]) == MAP_BASE[i]) return i;
        end
        return -1;
    endfunction

    // Drive one processor transaction while acting as the device set.
    // Starts and ends at a negedge with the bridge idle.
    task automatic txn(input string tag, input logic we, input logic [15:0] addr,
                       input logic [3:0] be, input word_t wd, input int waits,
                       input word_t rdata, input logic drop, input int exp_ch,
                       input logic exp_err, input word_t exp_rd,
                       input int exp_cycles, input int exp_acc);
        int          cycles;
        int          acc;
        int          lat_bad;
        logic [N-1:0] sel_or;
        logic        done;
        word_t       got_rd;
        logic        got_err;
        for (int i = 0; i < N; i++) begin
            bus.dev_rd[i*32 +: 32] = (i == exp_ch) ? rdata : word_t'($urandom);
        end
        bus.pr_req  = 1'b1;
        bus.pr_we   = we;
        bus.pr_addr = addr;
        bus.pr_be   = be;
        bus.pr_wd   = wd;
        cycles  = 1;
        acc     = 0;
        lat_bad = 0;
        sel_or  = '0;
        done    = 1'b0;
        got_rd  = '0;
        got_err = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (drop) bus.pr_req = 1'b0;
            if (bus.pr_ready) begin
                done    = 1'b1;
                got_rd  = bus.pr_rd;
                got_err = bus.pr_err;
                if (bus.dev_sel != '0 || bus.dev_we) lat_bad++;
                bus.dev_ack = '0;
            end else begin
                if (bus.dev_sel != '0) begin
                    acc++;
                    sel_or = sel_or | bus.dev_sel;
                    if (bus.dev_we !== we || bus.dev_addr !== addr ||
                        bus.dev_be !== be || bus.dev_wd !== wd) lat_bad++;
                end
                // Unselected channels raise spurious acks at random.
                bus.dev_ack = N'($urandom) & ~bus.dev_sel;
                if (bus.dev_sel != '0 && acc > waits) bus.dev_ack = bus.dev_ack | bus.dev_sel;
            end
        end
        bus.pr_req  = 1'b0;
        bus.dev_ack = '0;
        if (!done) begin
            check({tag, " ready_seen"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " pr_rd"},   got_rd, exp_rd);
        check({tag, " pr_err"},  32'(got_err), 32'(exp_err));
        check({tag, " latency"}, 32'(cycles), 32'(exp_cycles));
        check({tag, " dev_sel"}, 32'(sel_or), (exp_ch >= 0) ? (32'd1 << exp_ch) : 32'd0);
        check({tag, " access_cycles"}, 32'(acc), 32'(exp_acc));
        check({tag, " latched_bus"}, 32'(lat_bad), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " ready_pulse"}, 32'(bus.pr_ready), 32'd0);
        check({tag, " rd_hold"},     bus.pr_rd, exp_rd);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        word_t       wd;
        int          waits;
        word_t       rdata;
        logic        drop;
        int          exp_ch;
        logic        exp_err;
        word_t       exp_rd;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [5:0] prev_irq;
        int         ch;
        word_t      rdata;
        int         waits;
        logic [15:0] addr;
        int         sel;

        vecs[0]  = '{1'b0, 16'h0010, 4'hF, 32'h0,        0, 32'hDEADBEEF, 1'b0,  0, 1'b0, 32'hDEADBEEF, 3};
        vecs[1]  = '{1'b1, 16'h7F04, 4'hF, 32'h12345678, 3, 32'h000000A5, 1'b0,  1, 1'b0, 32'h000000A5, 6};
        vecs[2]  = '{1'b0, 16'h7FF0, 4'hF, 32'h0,        0, 32'h55555555, 1'b0, -1, 1'b1, 32'h0,        2};
        vecs[3]  = '{1'b0, 16'h7F1C, 4'hF, 32'h0,        1, 32'hCAFEF00D, 1'b0,  2, 1'b0, 32'hCAFEF00D, 4};
        vecs[4]  = '{1'b0, 16'h3FFC, 4'hF, 32'h0,        0, 32'h13579BDF, 1'b1,  0, 1'b0, 32'h13579BDF, 3};
        vecs[5]  = '{1'b0, 16'h4000, 4'hF, 32'h0,        0, 32'h0BADF00D, 1'b0, -1, 1'b1, 32'h0,        2};
        vecs[6]  = '{1'b1, 16'h7F20, 4'h3, 32'hA5A5A5A5, 2, 32'h11111111, 1'b1,  3, 1'b0, 32'h11111111, 5};
        vecs[7]  = '{1'b0, 16'h7F7C, 4'hF, 32'h0,        0, 32'h600DCAFE, 1'b0,  5, 1'b0, 32'h600DCAFE, 3};
        vecs[8]  = '{1'b0, 16'h7F80, 4'hF, 32'h0,        0, 32'h77777777, 1'b0, -1, 1'b1, 32'h0,        2};
        vecs[9]  = '{1'b1, 16'h00FF, 4'h8, 32'hFEEDFACE, 1, 32'h24682468, 1'b0,  0, 1'b0, 32'h24682468, 4};
        vecs[10] = '{1'b0, 16'h8000, 4'hF, 32'h0,        0, 32'h99999999, 1'b0, -1, 1'b1, 32'h0,        2};

        // Reset with every input active
        reset       = 1'b1;
        bus.pr_req  = 1'b1;
        bus.pr_we   = 1'b1;
        bus.pr_addr = 16'h0010;
        bus.pr_be   = 4'hF;
        bus.pr_wd   = 32'hFFFFFFFF;
        bus.dev_rd  = '1;
        bus.dev_ack = '1;
        bus.dev_irq = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pr_ready", 32'(bus.pr_ready), 32'd0);
        check("reset pr_err",   32'(bus.pr_err),   32'd0);
        check("reset pr_rd",    bus.pr_rd,         32'd0);
        check("reset dev_sel",  32'(bus.dev_sel),  32'd0);
        check("reset dev_we",   32'(bus.dev_we),   32'd0);
        check("reset dev_addr", 32'(bus.dev_addr), 32'd0);
        check("reset hw_int",   32'(bus.hw_int),   32'd0);
        bus.pr_req  = 1'b0;
        bus.dev_ack = '0;
        bus.dev_irq = '0;
        reset       = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd,
                vecs[i].waits, vecs[i].rdata, vecs[i].drop, vecs[i].exp_ch,
                vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_cycles,
                (vecs[i].exp_ch >= 0) ? vecs[i].waits + 1 : 0);
        end

        // Randomized transactions against the map model
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      addr = 16'($urandom_range(0, 16'h3FFF));
            else if (sel == 1) addr = 16'h7F00 | 16'($urandom_range(0, 255));
            else               addr = 16'($urandom);
            ch    = model_decode(addr);
            waits = int'($urandom_range(0, 4));
            rdata = $urandom;
            txn($sformatf("rnd%0d", t), 1'($urandom), addr, 4'($urandom), $urandom, waits,
                rdata, 1'($urandom), ch, (ch < 0), (ch < 0) ? 32'd0 : rdata,
                (ch < 0) ? 2 : waits + 3, (ch < 0) ? 0 : waits + 1);
        end

        // Reset during ACCESS abandons the transaction
        bus.pr_req  = 1'b1;
        bus.pr_we   = 1'b1;
        bus.pr_addr = 16'h0010;
        bus.pr_be   = 4'hF;
        bus.pr_wd   = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid dev_sel", 32'(bus.dev_sel), 32'd1);
        check("rstmid dev_we",  32'(bus.dev_we),  32'd1);
        reset       = 1'b1;
        bus.pr_req  = 1'b0;
        bus.dev_ack = '1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid sel_cleared", 32'(bus.dev_sel),  32'd0);
        check("rstmid we_cleared",  32'(bus.dev_we),   32'd0);
        check("rstmid no_ready",    32'(bus.pr_ready), 32'd0);
        reset       = 1'b0;
        bus.dev_ack = '0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid no_ready2", 32'(bus.pr_ready), 32'd0);
        txn("after_rst", 1'b0, 16'h0010, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0,
            0, 1'b0, 32'hDEADBEEF, 3, 1);

        // Interrupt registering
        bus.dev_irq = 7'b0000010;
        check("irq before_edge", 32'(bus.hw_int), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("irq raised", 32'(bus.hw_int), 32'b000010);
        bus.dev_irq = '0;
        @(posedge clk);
        @(negedge clk);
        check("irq cleared", 32'(bus.hw_int), 32'd0);
        bus.dev_irq = 7'b1000000;
        @(posedge clk);
        @(negedge clk);
        check("irq ch6_ignored", 32'(bus.hw_int), 32'd0);
        prev_irq = '0;
        for (int c = 0; c < 10; c++) begin
            bus.dev_irq = N'($urandom);
            prev_irq    = bus.dev_irq[5:0];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("irq rnd%0d", c), 32'(bus.hw_int), 32'(prev_irq));
        end
        bus.dev_irq = '0;
        @(posedge clk);
        @(negedge clk);

`ifdef SYS_BRIDGE_TIMEOUT_EN
        // No ack ever: abort after TMO ACCESS cycles
        txn("tmo_noack", 1'b0, 16'h7F14, 4'hF, 32'h0, 1000, 32'h12121212, 1'b0,
            2, 1'b1, 32'h0, TMO + 2, TMO);
        // Ack in the last permitted cycle wins
        txn("tmo_lastack", 1'b0, 16'h7F14, 4'hF, 32'h0, TMO - 1, 32'h34343434, 1'b0,
            2, 1'b0, 32'h34343434, TMO + 2, TMO);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
